mem_stage: RTL and testbench

- MEM pipeline stage; sits between EXEU and the WB stage.
- Latches the EXE-to-MEM bundle and receives the synchronous data-SRAM read data one cycle after EXE issued the request.
- Extracts and sign/zero-extends load data, then hands the result to WB.
- Also feeds MEM-stage write-back info back to ID, and MEM exception status back to EXE.
- Has a one-entry read-data hold buffer, so a load survives WB backpressure even though SRAM rdata is valid for only one cycle.

---
 rtl/mem_stage_pkg.sv | 61 ++++++
 rtl/mem_stage_load_align.sv | 32 +++
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, mem_op encodings and the
// EXE->MEM / MEM->WB bundle layouts that EXE, MEM and WB all pack and unpack.
package mem_stage_pkg;

  localparam int EXE2MEM_LEN = 172;
  localparam int MEM2WB_LEN  = 167;
  localparam int MEMRF_LEN   = 39;

  // bit3 = unsigned load, bit2 = store, [1:0] = access size
  localparam int MEMOP_UNSIGNED_BIT = 3;
  localparam int MEMOP_STORE_BIT    = 2;

  localparam logic [1:0] MEMOP_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEMOP_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEMOP_SIZE_WORD = 2'd2;

  localparam logic [3:0] MEMOP_LD_B  = 4'h0;
  localparam logic [3:0] MEMOP_LD_H  = 4'h1;
  localparam logic [3:0] MEMOP_LD_W  = 4'h2;
  localparam logic [3:0] MEMOP_ST_B  = 4'h4;
  localparam logic [3:0] MEMOP_ST_H  = 4'h5;
  localparam logic [3:0] MEMOP_ST_W  = 4'h6;
  localparam logic [3:0] MEMOP_LD_BU = 4'h8;
  localparam logic [3:0] MEMOP_LD_HU = 4'h9;

  // Packed structs list fields MSB first, so they double as the zip field offsets.
  typedef struct packed {
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [3:0]  mem_op;
    logic [31:0] pc;
    logic        csr_read;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
  } exe2mem_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
    logic [31:0] pc;
    logic        csr_read;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
  } mem2wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half/word out of a 32-bit read word and
// sign- or zero-extends it according to mem_op.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw_word_i,
  input  logic [1:0]  addr_i,
  input  logic [3:0]  mem_op_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;
  logic        unused_store_bit;

  // The store bit never affects extraction; loads are selected by the caller.
  assign unused_store_bit = mem_op_i[MEMOP_STORE_BIT];
  assign is_unsigned      = mem_op_i[MEMOP_UNSIGNED_BIT];
  assign byte_sel         = raw_word_i[8*addr_i +: 8];
  assign half_sel         = addr_i[1] ? raw_word_i[31:16] : raw_word_i[15:0];

  always_comb begin
    load_data_o = raw_word_i;
    case (mem_op_i[1:0])
      MEMOP_SIZE_BYTE: load_data_o = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      MEMOP_SIZE_HALF: load_data_o = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:         load_data_o = raw_word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE bundle, aligns SRAM load data (with a
// one-entry hold buffer for WB backpressure) and forwards results to WB/ID/EXE.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   exe_to_mem_valid,
  input  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
  output logic                   mem_allowin,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   wb_allowin,
  output logic                   mem_to_wb_valid,
  output logic [MEM2WB_LEN-1:0]  mem_to_wb_zip,
  output logic [MEMRF_LEN-1:0]   mem_rf_zip,
  output logic                   mem_ex
);

  exe2mem_t    exe_in;
  exe2mem_t    payload_q;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_first_q, mem_first_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_data_q, hold_data_d;

  logic        mem_ready_go;
  logic        accept;
  logic        leaving;
  logic        is_load;
  logic [31:0] raw_word;
  logic [31:0] load_data;
  logic [31:0] final_result;
  mem2wb_t     wb_out;

  assign exe_in       = exe2mem_t'(exe_to_mem_zip);
  assign mem_ready_go = 1'b1;
  assign mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);
  assign accept       = exe_to_mem_valid & mem_allowin;
  assign leaving      = mem_valid_q & mem_ready_go & wb_allowin;

  // A faulting or ertn instruction never issued its SRAM read, so rdata is junk.
  assign is_load  = payload_q.res_from_mem & ~payload_q.ex_valid & ~payload_q.is_ertn;
  assign raw_word = hold_valid_q ? hold_data_q : data_sram_rdata;

  load_align u_load_align (
    .raw_word_i  (raw_word),
    .addr_i      (payload_q.result[1:0]),
    .mem_op_i    (payload_q.mem_op),
    .load_data_o (load_data)
  );

  assign final_result = is_load ? load_data : payload_q.result;

  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_first_d  = accept;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = exe_to_mem_valid;
    end
    // rdata only exists on the first MEM cycle; park it if WB is stalling us.
    if (flush || leaving) begin
      hold_valid_d = 1'b0;
    end else if (mem_valid_q && mem_first_q && is_load && !wb_allowin) begin
      hold_valid_d = 1'b1;
      hold_data_d  = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q  <= 1'b0;
      mem_first_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 32'h0;
      payload_q    <= '0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_first_q  <= mem_first_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      if (accept) begin
        payload_q <= exe_in;
      end
    end
  end

  always_comb begin
    wb_out              = '0;
    wb_out.rf_we        = payload_q.rf_we;
    wb_out.rf_waddr     = payload_q.rf_waddr;
    wb_out.final_result = final_result;
    wb_out.pc           = payload_q.pc;
    wb_out.csr_read     = payload_q.csr_read;
    wb_out.csr_we       = payload_q.csr_we;
    wb_out.csr_num      = payload_q.csr_num;
    wb_out.csr_wmask    = payload_q.csr_wmask;
    wb_out.csr_wvalue   = payload_q.csr_wvalue;
    wb_out.ex_valid     = payload_q.ex_valid;
    wb_out.ecode        = payload_q.ecode;
    wb_out.esubcode     = payload_q.esubcode;
    wb_out.is_ertn      = payload_q.is_ertn;
  end

  assign mem_to_wb_valid = mem_valid_q;
  assign mem_to_wb_zip   = wb_out;
  assign mem_rf_zip      = {mem_valid_q & payload_q.csr_read, mem_valid_q & payload_q.rf_we,
                            payload_q.rf_waddr, final_result};
  assign mem_ex          = mem_valid_q & (payload_q.ex_valid | payload_q.is_ertn);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads of every size, WB stall with the hold
// buffer, ALU/store pass-through, exceptions, flush and mid-stall reset.
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic         flush;
  logic         exe_to_mem_valid;
  logic [171:0] exe_to_mem_zip;
  logic         mem_allowin;
  logic [31:0]  data_sram_rdata;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [166:0] mem_to_wb_zip;
  logic [38:0]  mem_rf_zip;
  logic         mem_ex;

  int checkCount;
  int errorCount;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_zip   (exe_to_mem_zip),
    .mem_allowin      (mem_allowin),
    .data_sram_rdata  (data_sram_rdata),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_zip    (mem_to_wb_zip),
    .mem_rf_zip       (mem_rf_zip),
    .mem_ex           (mem_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one EXE->MEM bundle; CSR fields stay zero throughout this bench.
  task automatic applyStimulus(input logic valid, input logic resFromMem, input logic rfWe,
                               input logic [4:0] waddr, input logic [31:0] result,
                               input logic [3:0] memOp, input logic [31:0] pc,
                               input logic exValid, input logic [5:0] ecode, input logic isErtn);
    exe_to_mem_valid = valid;
    exe_to_mem_zip   = {resFromMem, rfWe, waddr, result, memOp, pc, 1'b0, 1'b0, 14'h0,
                        32'h0, 32'h0, exValid, ecode, 9'h0, isErtn};
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount       = 0;
    errorCount       = 0;
    resetn           = 1'b0;
    flush            = 1'b0;
    wb_allowin       = 1'b1;
    data_sram_rdata  = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 1'b0, 6'h0, 1'b0);
    step;
    step;
    checkOutput("reset_valid", 64'(mem_to_wb_valid), 64'd0);
    checkOutput("reset_allowin", 64'(mem_allowin), 64'd1);
    checkOutput("reset_mem_ex", 64'(mem_ex), 64'd0);
    checkOutput("reset_rf_valid_bits", 64'(mem_rf_zip[38:37]), 64'd0);

    resetn = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 32'h1000, 4'h2, 32'h1c00_0000, 1'b0, 6'h0, 1'b0);
    step;
    data_sram_rdata = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd6, 32'h1003, 4'h0, 32'h1c00_0004, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("ldw_valid", 64'(mem_to_wb_valid), 64'd1);
    checkOutput("ldw_result", 64'(mem_to_wb_zip[160:129]), 64'hDEADBEEF);
    checkOutput("ldw_rf_zip", 64'(mem_rf_zip), 64'({1'b0, 1'b1, 5'd5, 32'hDEADBEEF}));
    checkOutput("ldw_pc", 64'(mem_to_wb_zip[128:97]), 64'h1c00_0000);

    step;
    data_sram_rdata = 32'h80112233;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd6, 32'h1003, 4'h8, 32'h1c00_0008, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("ldb_result", 64'(mem_to_wb_zip[160:129]), 64'hFFFFFF80);

    step;
    data_sram_rdata = 32'h80112233;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd6, 32'h1002, 4'h1, 32'h1c00_000c, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("ldbu_result", 64'(mem_to_wb_zip[160:129]), 64'h00000080);

    step;
    data_sram_rdata = 32'h80015555;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd8, 32'h2000, 4'h9, 32'h1c00_0010, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("ldh_result", 64'(mem_to_wb_zip[160:129]), 64'hFFFF8001);

    step;
    data_sram_rdata = 32'h0000F00D;
    wb_allowin = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("ldhu_stall1_result", 64'(mem_to_wb_zip[160:129]), 64'h0000F00D);
    checkOutput("ldhu_stall1_allowin", 64'(mem_allowin), 64'd0);
    step;
    data_sram_rdata = 32'h12345678;
    #1;
    checkOutput("ldhu_stall2_result", 64'(mem_to_wb_zip[160:129]), 64'h0000F00D);
    checkOutput("ldhu_stall2_hold", 64'(dut.hold_valid_q), 64'd1);
    checkOutput("ldhu_stall2_allowin", 64'(mem_allowin), 64'd0);
    step;
    #1;
    checkOutput("ldhu_stall3_result", 64'(mem_to_wb_zip[160:129]), 64'h0000F00D);
    checkOutput("ldhu_stall3_valid", 64'(mem_to_wb_valid), 64'd1);
    step;
    wb_allowin = 1'b1;
    #1;
    checkOutput("ldhu_release_result", 64'(mem_to_wb_zip[160:129]), 64'h0000F00D);
    checkOutput("ldhu_release_allowin", 64'(mem_allowin), 64'd1);
    step;
    #1;
    checkOutput("ldhu_after_hold", 64'(dut.hold_valid_q), 64'd0);
    checkOutput("ldhu_after_valid", 64'(mem_to_wb_valid), 64'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 32'h55, 4'h0, 32'h1c00_0020, 1'b0, 6'h0, 1'b0);
    step;
    data_sram_rdata = 32'hAAAAAAAA;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd9, 32'h3000, 4'h6, 32'h1c00_0024, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("add_rf_zip", 64'(mem_rf_zip), 64'({1'b0, 1'b1, 5'd7, 32'h55}));
    step;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd10, 32'h1001, 4'h2, 32'h1c00_0028, 1'b1, 6'h0B, 1'b0);
    #1;
    checkOutput("stw_result", 64'(mem_to_wb_zip[160:129]), 64'h3000);
    checkOutput("stw_rf_we", 64'(mem_rf_zip[37]), 64'd0);
    checkOutput("stw_mem_ex", 64'(mem_ex), 64'd0);

    step;
    data_sram_rdata = 32'hCAFEF00D;
    flush = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd11, 32'h4000, 4'h2, 32'h1c00_002c, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("exc_mem_ex", 64'(mem_ex), 64'd1);
    checkOutput("exc_result_is_addr", 64'(mem_to_wb_zip[160:129]), 64'h1001);
    checkOutput("exc_wb_ex_ecode", 64'(mem_to_wb_zip[16:10]), 64'({1'b1, 6'h0B}));
    step;
    flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("flush_valid", 64'(mem_to_wb_valid), 64'd0);
    checkOutput("flush_mem_ex", 64'(mem_ex), 64'd0);
    checkOutput("flush_rf_we", 64'(mem_rf_zip[37]), 64'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 5'd12, 32'h5000, 4'h2, 32'h1c00_0030, 1'b0, 6'h0, 1'b0);
    step;
    wb_allowin = 1'b0;
    data_sram_rdata = 32'h11112222;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 1'b0, 6'h0, 1'b0);
    #1;
    checkOutput("rst_stall_valid", 64'(mem_to_wb_valid), 64'd1);
    step;
    #1;
    checkOutput("rst_stall_hold", 64'(dut.hold_valid_q), 64'd1);
    checkOutput("rst_stall_result", 64'(mem_to_wb_zip[160:129]), 64'h11112222);
    resetn = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 64'(mem_to_wb_valid), 64'd0);
    checkOutput("rst_mid_hold", 64'(dut.hold_valid_q), 64'd0);
    checkOutput("rst_mid_allowin", 64'(mem_allowin), 64'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
